mips_mdu: RTL and testbench

MIPS_MDU -- requirements
Module: mips_mdu

---
 rtl/mips_mdu.sv | 113 +++++++++++
 tb/tb_mips_mdu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mdu.sv
// mips_mdu: multi-cycle MIPS multiply/divide unit with the HI/LO registers.
// The result is computed in the start cycle and committed to HI/LO after a fixed busy latency.
module mips_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    localparam int CW = 16;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic          dz_q, dz_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic        is_mul, is_div, dv_signed, a_neg, b_neg;
    logic [31:0] a_abs, b_abs, q_abs, r_abs, q_fin, r_fin;
    logic [63:0] prod_s, prod_u;

    assign is_mul = start && (MDU_op == 5'd1 || MDU_op == 5'd2);
    assign is_div = start && (MDU_op == 5'd3 || MDU_op == 5'd4);

    // Sign-extending to 64 bits makes the truncated unsigned product the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    // Signed divide via magnitudes so that -2^31 / -1 wraps cleanly instead of trapping.
    assign dv_signed = MDU_op == 5'd3;
    assign a_neg     = dv_signed && A[31];
    assign b_neg     = dv_signed && B[31];
    assign a_abs     = a_neg ? -A : A;
    assign b_abs     = b_neg ? -B : B;
    assign q_abs     = (b_abs == 32'd0) ? 32'd0 : a_abs / b_abs;
    assign r_abs     = (b_abs == 32'd0) ? 32'd0 : a_abs % b_abs;
    assign q_fin     = (a_neg ^ b_neg) ? -q_abs : q_abs;
    assign r_fin     = a_neg ? -r_abs : r_abs;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    state_d = MUL;
                    cnt_d   = CW'(MULT_CYCLES);
                    res_d   = (MDU_op == 5'd1) ? prod_s : prod_u;
                    dz_d    = 1'b0;
                end else if (is_div) begin
                    state_d = DIV;
                    cnt_d   = CW'(DIV_CYCLES);
                    res_d   = {r_fin, q_fin};
                    dz_d    = B == 32'd0;
                end else begin
                    hi_d = (MDU_op == 5'd7) ? A : hi_q;
                    lo_d = (MDU_op == 5'd8) ? A : lo_q;
                end
            end
            default: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = dz_q ? hi_q : res_q[63:32];
                    lo_d    = dz_q ? lo_q : res_q[31:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign stall_req = busy | start;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign MDU_out   = (MDU_op == 5'd5) ? hi_q : (MDU_op == 5'd6) ? lo_q : 32'd0;

    // The hazard unit must hold back new MDU work until the current operation commits.
    assert property (@(posedge clk) disable iff (!reset_n)
        busy |-> !(start || MDU_op == 5'd7 || MDU_op == 5'd8));
endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: directed self-checking bench for the MIPS multiply/divide unit.
module tb_mips_mdu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  MDU_op = 5'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, stall_req;
    logic [31:0] HI, LO, MDU_out;
    int passed = 0;
    int total = 0;

    mips_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .MDU_op(MDU_op), .A(A), .B(B),
        .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO), .MDU_out(MDU_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start, scrambles the operands afterwards, and counts busy cycles.
    task automatic run_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic st0, output int n);
        start = 1'b1; MDU_op = op; A = a; B = b;
        #1;
        st0 = stall_req;
        tick();
        start = 1'b0; MDU_op = 5'd0; A = 32'hA5A5_5A5A; B = 32'h0000_0003;
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        MDU_op = 5'd5;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (stall_req !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_req); else passed++;
        total++; if (HI !== 32'd0) $display("FAIL rst_hi: got %h want 0", HI); else passed++;
        total++; if (LO !== 32'd0) $display("FAIL rst_lo: got %h want 0", LO); else passed++;
        total++; if (MDU_out !== 32'd0) $display("FAIL rst_mfhi: got %h want 0", MDU_out); else passed++;
        MDU_op = 5'd0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic s; int n;
        run_mdu(5'd1, 32'hFFFF_FFFF, 32'd2, s, n);
        total++; if (s !== 1'b1) $display("FAIL mult_stall0: got %b want 1", s); else passed++;
        total++; if (n !== 5) $display("FAIL mult_busy: got %0d want 5", n); else passed++;
        total++; if (HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", HI); else passed++;
        total++; if (LO !== 32'hFFFF_FFFE) $display("FAIL mult_lo: got %h want fffffffe", LO); else passed++;
        run_mdu(5'd2, 32'hFFFF_FFFF, 32'd2, s, n);
        total++; if (n !== 5) $display("FAIL multu_busy: got %0d want 5", n); else passed++;
        total++; if (HI !== 32'h0000_0001) $display("FAIL multu_hi: got %h want 00000001", HI); else passed++;
        total++; if (LO !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want fffffffe", LO); else passed++;
        run_mdu(5'd1, 32'hFFFF_FFFD, 32'd5, s, n);
        total++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mult_neg: got %h%h want fffffffffffffff1", HI, LO); else passed++;
        run_mdu(5'd2, 32'h8000_0000, 32'h8000_0000, s, n);
        total++; if ({HI, LO} !== 64'h4000_0000_0000_0000) $display("FAIL multu_big: got %h%h want 4000000000000000", HI, LO); else passed++;
    endtask

    task automatic test_div();
        logic s; int n;
        run_mdu(5'd3, 32'hFFFF_FFF9, 32'd2, s, n);
        total++; if (s !== 1'b1) $display("FAIL div_stall0: got %b want 1", s); else passed++;
        total++; if (n !== 10) $display("FAIL div_busy: got %0d want 10", n); else passed++;
        total++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", LO); else passed++;
        total++; if (HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", HI); else passed++;
        run_mdu(5'd4, 32'd7, 32'd2, s, n);
        total++; if (n !== 10) $display("FAIL divu_busy: got %0d want 10", n); else passed++;
        total++; if (LO !== 32'd3) $display("FAIL divu_lo: got %h want 00000003", LO); else passed++;
        total++; if (HI !== 32'd1) $display("FAIL divu_hi: got %h want 00000001", HI); else passed++;
        run_mdu(5'd3, 32'd7, 32'hFFFF_FFFE, s, n);
        total++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFD) $display("FAIL div_negdivisor: got %h%h want 00000001fffffffd", HI, LO); else passed++;
        run_mdu(5'd4, 32'hFFFF_FFF9, 32'd2, s, n);
        total++; if ({HI, LO} !== 64'h0000_0001_7FFF_FFFC) $display("FAIL divu_big: got %h%h want 000000017ffffffc", HI, LO); else passed++;
        run_mdu(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, s, n);
        total++; if ({HI, LO} !== 64'h0000_0000_8000_0000) $display("FAIL div_overflow: got %h%h want 0000000080000000", HI, LO); else passed++;
    endtask

    task automatic test_divzero();
        logic s; int n;
        MDU_op = 5'd8; A = 32'h1234;
        tick();
        MDU_op = 5'd7; A = 32'h5678;
        tick();
        MDU_op = 5'd6; A = 32'd0;
        #1;
        total++; if (MDU_out !== 32'h1234) $display("FAIL mtlo_mflo: got %h want 00001234", MDU_out); else passed++;
        total++; if (HI !== 32'h5678) $display("FAIL mthi_hi: got %h want 00005678", HI); else passed++;
        run_mdu(5'd3, 32'd5, 32'd0, s, n);
        total++; if (n !== 10) $display("FAIL divz_busy: got %0d want 10", n); else passed++;
        total++; if (HI !== 32'h5678) $display("FAIL divz_hi: got %h want 00005678", HI); else passed++;
        total++; if (LO !== 32'h1234) $display("FAIL divz_lo: got %h want 00001234", LO); else passed++;
    endtask

    task automatic test_mt_mf();
        MDU_op = 5'd7; A = 32'hDEAD_BEEF;
        tick();
        MDU_op = 5'd5; A = 32'd0;
        #1;
        total++; if (MDU_out !== 32'hDEAD_BEEF) $display("FAIL mfhi: got %h want deadbeef", MDU_out); else passed++;
        MDU_op = 5'd6;
        #1;
        total++; if (MDU_out !== 32'h1234) $display("FAIL mflo: got %h want 00001234", MDU_out); else passed++;
        MDU_op = 5'd0;
        #1;
        total++; if (MDU_out !== 32'd0) $display("FAIL mf_none: got %h want 0", MDU_out); else passed++;
        MDU_op = 5'd9;
        #1;
        total++; if (MDU_out !== 32'd0) $display("FAIL mf_badop: got %h want 0", MDU_out); else passed++;
        MDU_op = 5'd0;
    endtask

    task automatic test_stall();
        start = 1'b1; MDU_op = 5'd1; A = 32'd3; B = 32'd4;
        #1;
        total++; if (stall_req !== 1'b1) $display("FAIL stall_t: got %b want 1", stall_req); else passed++;
        tick();
        start = 1'b0; MDU_op = 5'd5; A = 32'd99; B = 32'd99;
        for (int i = 1; i <= 5; i++) begin
            total++; if (stall_req !== 1'b1) $display("FAIL stall_t+%0d: got %b want 1", i, stall_req); else passed++;
            if (i == 2) begin
                total++; if (MDU_out !== 32'hDEAD_BEEF) $display("FAIL mfhi_busy: got %h want deadbeef", MDU_out); else passed++;
            end
            tick();
        end
        total++; if (stall_req !== 1'b0) $display("FAIL stall_after: got %b want 0", stall_req); else passed++;
        total++; if ({HI, LO} !== 64'd12) $display("FAIL stall_result: got %h%h want 000000000000000c", HI, LO); else passed++;
        MDU_op = 5'd0;
    endtask

    task automatic test_back_to_back();
        logic s; int n;
        run_mdu(5'd4, 32'd100, 32'd7, s, n);
        total++; if ({HI, LO} !== 64'h0000_0002_0000_000E) $display("FAIL b2b_divu: got %h%h want 000000020000000e", HI, LO); else passed++;
        run_mdu(5'd1, 32'hFFFF_FFFE, 32'h7FFF_FFFF, s, n);
        total++; if (n !== 5) $display("FAIL b2b_busy: got %0d want 5", n); else passed++;
        total++; if ({HI, LO} !== 64'hFFFF_FFFF_0000_0002) $display("FAIL b2b_mult: got %h%h want ffffffff00000002", HI, LO); else passed++;
    endtask

    task automatic test_reset_mid();
        logic s; int n;
        start = 1'b1; MDU_op = 5'd2; A = 32'd1000; B = 32'd1000;
        tick();
        start = 1'b0; MDU_op = 5'd0;
        tick(); tick();
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        total++; if (HI !== 32'd0) $display("FAIL mid_hi: got %h want 0", HI); else passed++;
        total++; if (LO !== 32'd0) $display("FAIL mid_lo: got %h want 0", LO); else passed++;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        total++; if ({busy, HI, LO} !== 65'd0) $display("FAIL mid_after: got %b %h %h want 0 0 0", busy, HI, LO); else passed++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run_mdu(5'd2, 32'd6, 32'd7, s, n);
        total++; if (n !== 5) $display("FAIL post_rst_busy: got %0d want 5", n); else passed++;
        total++; if (LO !== 32'd42) $display("FAIL post_rst_lo: got %h want 0000002a", LO); else passed++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_mt_mf();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
